// File: rtl/cache_pkg.sv
// Shared types and defaults for the cache data array.
// Combinational only: constants, state enum and a byte-parity helper.
// No flow control lives here.
package cache_pkg;

  localparam int DEFAULT_LINE_BITS = 128;
  localparam int DEFAULT_DEPTH     = 1024;

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } cache_da_state_t;

  // Even parity: the stored bit makes the total count of ones even.
  function automatic logic byte_parity(input logic [7:0] b);
    return ^b;
  endfunction

endpackage

// File: rtl/cache_data_array_if.sv
// Request/response bundle between cache controller (master) and data array (slave).
// Pure wiring, no latency.
// req_ready gates requests; responses have no backpressure. parity_err exists with CACHE_DA_PARITY_EN.
interface cache_data_array_if
  import cache_pkg::*;
#(
  parameter int LINE_BITS = DEFAULT_LINE_BITS,
  parameter int DEPTH     = DEFAULT_DEPTH
);
  localparam int IDX_BITS = $clog2(DEPTH);

  logic                   req_valid;
  logic                   req_ready;
  logic                   req_write;
  logic [IDX_BITS-1:0]    req_index;
  logic [LINE_BITS-1:0]   req_wdata;
  logic [LINE_BITS/8-1:0] req_wmask;
  logic                   rsp_valid;
  logic [LINE_BITS-1:0]   rsp_rdata;
  logic                   init_busy;
`ifdef CACHE_DA_PARITY_EN
  logic                   parity_err;
`endif

  modport master (
    output req_valid, req_write, req_index, req_wdata, req_wmask,
    input
`ifdef CACHE_DA_PARITY_EN
          parity_err,
`endif
          req_ready, rsp_valid, rsp_rdata, init_busy
  );

  modport slave (
    input  req_valid, req_write, req_index, req_wdata, req_wmask,
    output
`ifdef CACHE_DA_PARITY_EN
           parity_err,
`endif
           req_ready, rsp_valid, rsp_rdata, init_busy
  );

endinterface

// File: rtl/cache_byte_ram.sv
// One byte lane of the data array: DEPTH x 8 (+ even-parity bit with CACHE_DA_PARITY_EN).
// Registered read: data visible the cycle after re; write lands at the edge.
// No backpressure; read register holds its value while re is low.
module cache_byte_ram
  import cache_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH,
  localparam int IDX_BITS = $clog2(DEPTH)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                we,
  input  logic                re,
  input  logic [IDX_BITS-1:0] addr,
  input  logic [7:0]          wdata,
`ifdef CACHE_DA_PARITY_EN
  output logic                perr,
`endif
  output logic [7:0]          rdata
);

  logic [7:0] mem_q [DEPTH];
  logic [7:0] rd_data_q, rd_data_d;

  // Storage array; cleared by the top-level sweep, so no reset here.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[addr] <= wdata;
    end
  end

  // Next read register value: load on read, otherwise hold.
  always_comb begin
    rd_data_d = rd_data_q;
    if (re) begin
      rd_data_d = mem_q[addr];
    end
  end

  // Read data register.
  always_ff @(posedge clk) begin
    if (!reset) begin
      rd_data_q <= '0;
    end else begin
      rd_data_q <= rd_data_d;
    end
  end

  assign rdata = rd_data_q;

`ifdef CACHE_DA_PARITY_EN
  logic par_mem_q [DEPTH];
  logic rd_par_q, rd_par_d;

  // Parity storage written alongside the data byte.
  always_ff @(posedge clk) begin
    if (we) begin
      par_mem_q[addr] <= byte_parity(wdata);
    end
  end

  // Next stored-parity register value, tracks the data register.
  always_comb begin
    rd_par_d = rd_par_q;
    if (re) begin
      rd_par_d = par_mem_q[addr];
    end
  end

  // Stored-parity read register.
  always_ff @(posedge clk) begin
    if (!reset) begin
      rd_par_q <= 1'b0;
    end else begin
      rd_par_q <= rd_par_d;
    end
  end

  // Recompute on the registered byte so the check sees exactly what is returned.
  assign perr = byte_parity(rd_data_q) ^ rd_par_q;
`endif

endmodule

// File: rtl/cache_data_array.sv
// Cache data array: DEPTH lines x LINE_BITS, byte-masked writes, clear sweep after reset.
// Reads: 1-cycle registered latency, full throughput; sweep takes DEPTH cycles.
// req_ready low during sweep (requests dropped); no response backpressure. Option: CACHE_DA_PARITY_EN.
module cache_data_array
  import cache_pkg::*;
#(
  parameter int LINE_BITS = DEFAULT_LINE_BITS,
  parameter int DEPTH     = DEFAULT_DEPTH
) (
  input logic               clk,
  input logic               reset,
  cache_data_array_if.slave bus
);

  localparam int IDX_BITS  = $clog2(DEPTH);
  localparam int NUM_LANES = LINE_BITS / 8;
  localparam logic [IDX_BITS-1:0] LAST_IDX = IDX_BITS'(DEPTH - 1);

  cache_da_state_t      state_q, state_d;
  logic [IDX_BITS-1:0]  cnt_q, cnt_d;
  logic                 rsp_valid_q, rsp_valid_d;
  logic                 accept;
  logic                 rd_accept;
  logic                 wr_accept;
  logic [IDX_BITS-1:0]  lane_addr;
  logic [LINE_BITS-1:0] lane_wdata;
  logic [NUM_LANES-1:0] lane_we;
  logic [LINE_BITS-1:0] rd_line;

  // Next state, sweep counter and lane controls; sweep owns the lanes in CLEAR.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    accept      = (state_q == RUN) && bus.req_valid;
    rd_accept   = accept && !bus.req_write;
    wr_accept   = accept && bus.req_write;
    rsp_valid_d = rd_accept;
    lane_addr   = bus.req_index;
    lane_wdata  = bus.req_wdata;
    lane_we     = {NUM_LANES{wr_accept}} & bus.req_wmask;
    case (state_q)
      CLEAR: begin
        lane_addr  = cnt_q;
        lane_wdata = '0;
        lane_we    = '1;
        cnt_d      = cnt_q + IDX_BITS'(1);
        if (cnt_q == LAST_IDX) begin
          state_d = RUN;
        end
      end
      RUN: begin
        state_d = RUN;
      end
      default: begin
        state_d = CLEAR;
        cnt_d   = '0;
      end
    endcase
  end

  // State, sweep counter and response-valid registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= CLEAR;
      cnt_q       <= '0;
      rsp_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rsp_valid_q <= rsp_valid_d;
    end
  end

`ifdef CACHE_DA_PARITY_EN
  logic [NUM_LANES-1:0] lane_perr;
`endif

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    cache_byte_ram #(
      .DEPTH (DEPTH)
    ) u_lane (
      .clk   (clk),
      .reset (reset),
      .we    (lane_we[i]),
      .re    (rd_accept),
      .addr  (lane_addr),
      .wdata (lane_wdata[8*i +: 8]),
`ifdef CACHE_DA_PARITY_EN
      .perr  (lane_perr[i]),
`endif
      .rdata (rd_line[8*i +: 8])
    );
  end

  assign bus.req_ready = (state_q == RUN);
  assign bus.init_busy = (state_q == CLEAR);
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rd_line;
`ifdef CACHE_DA_PARITY_EN
  // Lane read registers hold between reads, so qualify with the response pulse.
  assign bus.parity_err = rsp_valid_q && (|lane_perr);
`endif

endmodule
